// File: rtl/multi_fx_meter.sv
// rtl/multi_fx_meter.sv - multi-channel equal-precision frequency meter with ch0->ch1 phase delay
module multi_fx_meter #(
   parameter int CH          = 2,
   parameter int CNT_W       = 32,
   parameter int GATE_CYC    = 100_000_000,
   parameter int TIMEOUT_CYC = 100_000_000
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                cont,
   input  logic [CH-1:0]       fx_in,
   output logic [CH*CNT_W-1:0] fx_cnt_o,
   output logic [CH*CNT_W-1:0] ref_cnt_o,
   output logic [CNT_W-1:0]    phase_cnt_o,
   output logic [CH-1:0]       timeout_o,
   output logic [CH-1:0]       ovf_o,
   output logic                valid,
   output logic                busy
);

   localparam int TMR_MAX = (GATE_CYC > TIMEOUT_CYC) ? GATE_CYC : TIMEOUT_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYC - 1);
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] ONES      = '1;

   typedef enum logic [1:0] {S_IDLE, S_GATE, S_WAIT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CH-1:0]      sync1_q, sync2_q, sync3_q, fx_edge;
   logic [CH-1:0]      open_q, open_d, closed_q, closed_d, ovfw_q, ovfw_d;
   logic [CNT_W-1:0]   nx_q [CH];
   logic [CNT_W-1:0]   nx_d [CH];
   logic [CNT_W-1:0]   ns_q [CH];
   logic [CNT_W-1:0]   ns_d [CH];
   logic               soft_gate;
   logic               valid_q;

   // Edge pulse is taken after the two synchroniser flops, so both gate ends see the same lag.
   assign fx_edge   = sync2_q & ~sync3_q;
   assign soft_gate = (state_q == S_GATE);
   assign busy      = (state_q != S_IDLE);
   assign valid     = valid_q;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (start || cont) state_d = S_GATE;
         end
         S_GATE: begin
            if (tmr_q == GATE_LAST) begin
               state_d = S_WAIT;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         S_WAIT: begin
            if ((&closed_q) || (tmr_q == TO_LAST)) state_d = S_DONE;
            else tmr_d = tmr_q + TMR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      open_d   = open_q;
      closed_d = closed_q;
      ovfw_d   = ovfw_q;
      nx_d     = nx_q;
      ns_d     = ns_q;
      for (int i = 0; i < CH; i++) begin
         if (state_q == S_IDLE) begin
            open_d[i]   = 1'b0;
            closed_d[i] = 1'b0;
            ovfw_d[i]   = 1'b0;
            nx_d[i]     = '0;
            ns_d[i]     = '0;
         end else if (!open_q[i]) begin
            if (soft_gate && fx_edge[i]) open_d[i] = 1'b1;
         end else if (!closed_q[i]) begin
            if (ns_q[i] == ONES) ovfw_d[i] = 1'b1;
            else ns_d[i] = ns_q[i] + CNT_W'(1);
            if (fx_edge[i]) begin
               if (nx_q[i] == ONES) ovfw_d[i] = 1'b1;
               else nx_d[i] = nx_q[i] + CNT_W'(1);
               if (!soft_gate) closed_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         sync3_q   <= '0;
         open_q    <= '0;
         closed_q  <= '0;
         ovfw_q    <= '0;
         valid_q   <= 1'b0;
         fx_cnt_o  <= '0;
         ref_cnt_o <= '0;
         timeout_o <= '0;
         ovf_o     <= '0;
         for (int i = 0; i < CH; i++) begin
            nx_q[i] <= '0;
            ns_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         sync1_q  <= fx_in;
         sync2_q  <= sync1_q;
         sync3_q  <= sync2_q;
         open_q   <= open_d;
         closed_q <= closed_d;
         ovfw_q   <= ovfw_d;
         nx_q     <= nx_d;
         ns_q     <= ns_d;
         valid_q  <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            // A channel that never closed reports zero counts and a timeout flag.
            for (int i = 0; i < CH; i++) begin
               timeout_o[i]                 <= ~closed_q[i];
               ovf_o[i]                     <= ovfw_q[i];
               fx_cnt_o[i*CNT_W +: CNT_W]   <= closed_q[i] ? nx_q[i] : '0;
               ref_cnt_o[i*CNT_W +: CNT_W]  <= closed_q[i] ? ns_q[i] : '0;
            end
         end
      end
   end

   generate
      if (CH >= 2) begin : g_phase
         logic             ph_arm_q, ph_arm_d, ph_done_q, ph_done_d;
         logic [CNT_W-1:0] ph_q, ph_d, ph_res_q;
         logic             arm_ok;

         // ch0 edge that opens its gate or falls inside the still-open gate.
         assign arm_ok = fx_edge[0] &&
                         ((soft_gate && !open_q[0]) || (open_q[0] && !closed_q[0]));

         always_comb begin
            ph_arm_d  = ph_arm_q;
            ph_done_d = ph_done_q;
            ph_d      = ph_q;
            if (state_q == S_IDLE) begin
               ph_arm_d  = 1'b0;
               ph_done_d = 1'b0;
               ph_d      = '0;
            end else if (!ph_arm_q) begin
               if (arm_ok) begin
                  ph_arm_d = 1'b1;
                  if (fx_edge[1]) ph_done_d = 1'b1;
               end
            end else if (!ph_done_q) begin
               if (ph_q != ONES) ph_d = ph_q + CNT_W'(1);
               if (fx_edge[1]) ph_done_d = 1'b1;
            end
         end

         always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
               ph_arm_q  <= 1'b0;
               ph_done_q <= 1'b0;
               ph_q      <= '0;
               ph_res_q  <= '0;
            end else begin
               ph_arm_q  <= ph_arm_d;
               ph_done_q <= ph_done_d;
               ph_q      <= ph_d;
               if (state_q == S_DONE) ph_res_q <= ph_done_q ? ph_q : ONES;
            end
         end

         assign phase_cnt_o = ph_res_q;
      end else begin : g_no_phase
         assign phase_cnt_o = '0;
      end
   endgenerate

endmodule

// File: tb/tb_multi_fx_meter.sv
// tb/tb_multi_fx_meter.sv - directed bench for multi_fx_meter with a scaled gate
module tb_multi_fx_meter;

   localparam int G   = 2000;
   localparam int T   = 4000;
   localparam int PER = 200;
   localparam int DLY = 5;

   logic        sys_clk, rst_n, start, cont;
   logic [1:0]  fx_in;
   logic [63:0] fx_cnt, ref_cnt;
   logic [31:0] phase;
   logic [1:0]  to, ovf;
   logic        valid, busy;
   logic [15:0] fx_cnt_s, ref_cnt_s;
   logic [7:0]  phase_s;
   logic [1:0]  to_s, ovf_s;
   logic        valid_s, busy_s;

   int n_checks = 0;
   int n_errors = 0;
   int vcnt     = 0;
   int cyc      = 0;
   int mode     = 0;   // 0: ch1 delayed, 1: ch1 low, 2: ch1 = ch0

   multi_fx_meter #(.CH(2), .CNT_W(32), .GATE_CYC(G), .TIMEOUT_CYC(T)) u_dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .cont(cont), .fx_in(fx_in),
      .fx_cnt_o(fx_cnt), .ref_cnt_o(ref_cnt), .phase_cnt_o(phase),
      .timeout_o(to), .ovf_o(ovf), .valid(valid), .busy(busy));

   multi_fx_meter #(.CH(2), .CNT_W(8), .GATE_CYC(G), .TIMEOUT_CYC(T)) u_sat (
      .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .cont(cont), .fx_in(fx_in),
      .fx_cnt_o(fx_cnt_s), .ref_cnt_o(ref_cnt_s), .phase_cnt_o(phase_s),
      .timeout_o(to_s), .ovf_o(ovf_s), .valid(valid_s), .busy(busy_s));

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      fx_in = 2'b00;
      forever begin
         @(negedge sys_clk);
         cyc++;
         fx_in[0] = ((cyc % PER) < PER/2);
         case (mode)
            0:       fx_in[1] = (((cyc + PER - DLY) % PER) < PER/2);
            1:       fx_in[1] = 1'b0;
            default: fx_in[1] = fx_in[0];
         endcase
      end
   end

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (valid) vcnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int budget, output int cycles);
      bit ok = 1'b0;
      cycles = 0;
      for (int k = 1; k <= budget && !ok; k++) begin
         @(posedge sys_clk);
         #1;
         if (valid) begin
            ok     = 1'b1;
            cycles = k;
         end
      end
      check({tag, "_valid_seen"}, 64'(ok), 64'd1);
   endtask

   task automatic check_nominal(input string tag);
      check({tag, "_nx0"},   fx_cnt[31:0],   64'd10);
      check({tag, "_nx1"},   fx_cnt[63:32],  64'd10);
      check({tag, "_ns0"},   ref_cnt[31:0],  64'd2000);
      check({tag, "_ns1"},   ref_cnt[63:32], 64'd2000);
      check({tag, "_phase"}, phase,          64'd5);
      check({tag, "_to"},    to,             64'd0);
      check({tag, "_ovf"},   ovf,            64'd0);
   endtask

   int lat, vbase;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cont  = 1'b0;
      repeat (5) @(posedge sys_clk);
      #1;
      check("rst_fx",    fx_cnt,  64'd0);
      check("rst_ref",   ref_cnt, 64'd0);
      check("rst_phase", phase,   64'd0);
      check("rst_flags", {to, ovf}, 64'd0);
      check("rst_valid", valid,   64'd0);
      check("rst_busy",  busy,    64'd0);
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (20) @(posedge sys_clk);

      // nominal single measurement, plus the 8-bit instance saturating Ns
      pulse_start();
      check("t1_busy", busy, 64'd1);
      wait_valid("t1", 3000, lat);
      check_nominal("t1");
      check("t1_sat_valid", valid_s,          64'd1);
      check("t1_sat_nx0",   fx_cnt_s[7:0],    64'd10);
      check("t1_sat_ns0",   ref_cnt_s[7:0],   64'hFF);
      check("t1_sat_ns1",   ref_cnt_s[15:8],  64'hFF);
      check("t1_sat_ovf",   ovf_s,            64'd3);
      check("t1_sat_phase", phase_s,          64'd5);
      @(posedge sys_clk);
      #1;
      check("t1_valid_pulse", valid, 64'd0);
      check("t1_hold_nx0",    fx_cnt[31:0], 64'd10);

      // ch1 silent -> timeout on ch1, latency = gate + timeout + DONE
      mode = 1;
      repeat (20) @(posedge sys_clk);
      pulse_start();
      wait_valid("t2", 7000, lat);
      check("t2_latency", lat,            64'(G + T + 1));
      check("t2_to",      to,             64'd2);
      check("t2_nx1",     fx_cnt[63:32],  64'd0);
      check("t2_ns1",     ref_cnt[63:32], 64'd0);
      check("t2_nx0",     fx_cnt[31:0],   64'd10);
      check("t2_ns0",     ref_cnt[31:0],  64'd2000);
      check("t2_phase",   phase,          64'hFFFF_FFFF);

      // continuous mode: three runs, then stop
      mode = 0;
      repeat (300) @(posedge sys_clk);
      vbase = vcnt;
      @(negedge sys_clk);
      cont = 1'b1;
      wait_valid("t3a", 3000, lat);
      check_nominal("t3a");
      wait_valid("t3b", 3000, lat);
      check_nominal("t3b");
      for (int k = 0; k < 5 && !busy; k++) begin
         @(posedge sys_clk);
         #1;
      end
      check("t3_restart_busy", busy, 64'd1);
      @(negedge sys_clk);
      cont = 1'b0;
      wait_valid("t3c", 3000, lat);
      check_nominal("t3c");
      repeat (2500) @(posedge sys_clk);
      #1;
      check("t3_valid_count", vcnt - vbase, 64'd3);
      check("t3_busy_after",  busy,         64'd0);

      // reset in the middle of the gate
      pulse_start();
      repeat (500) @(posedge sys_clk);
      #1;
      vbase = vcnt;
      rst_n = 1'b0;
      #1;
      check("t5_fx",    fx_cnt,  64'd0);
      check("t5_ref",   ref_cnt, 64'd0);
      check("t5_phase", phase,   64'd0);
      check("t5_flags", {to, ovf}, 64'd0);
      check("t5_busy",  busy,    64'd0);
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (2500) @(posedge sys_clk);
      #1;
      check("t5_no_valid", vcnt - vbase, 64'd0);
      pulse_start();
      wait_valid("t5", 3000, lat);
      check_nominal("t5");

      // zero skew and a second start while busy
      mode = 2;
      repeat (300) @(posedge sys_clk);
      vbase = vcnt;
      pulse_start();
      repeat (10) @(negedge sys_clk);
      pulse_start();
      wait_valid("t6", 3000, lat);
      check("t6_phase", phase,          64'd0);
      check("t6_nx1",   fx_cnt[63:32],  64'd10);
      check("t6_ns1",   ref_cnt[63:32], 64'd2000);
      repeat (2500) @(posedge sys_clk);
      #1;
      check("t6_valid_count", vcnt - vbase, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
